snake_game_engine: RTL

Game-state sequencer for the snake display path. It owns the snake body, the food cell, the snake length and the game-state flags, and advances them one grid step per movement tick. Its outputs feed the renderer directly: `Locations_Flat`, `Length`, `Food`, `Qi`, `Qw`, `Ql` and `Qc`. The playfield is a 16×16 grid of 30 px cells; a cell index is `{y[3:0], x[3:0]}`.

---
 rtl/snake_pkg.sv | 55 +++++
 rtl/snake_occupancy.sv | 19 +
 rtl/snake_game_engine.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game engine.
// Holds the state/direction enums, grid geometry, start-up values and LFSR helpers.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_PLACE  = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int GRID_W   = 16;
  localparam int GRID_H   = 16;
  localparam int NUM_SEGS = 16;

  localparam logic [7:0]   INIT_HEAD = 8'h77;
  localparam logic [7:0]   INIT_SEG1 = 8'h76;
  localparam logic [7:0]   INIT_FOOD = 8'h7B;
  localparam logic [7:0]   LFSR_SEED = 8'h5A;
  localparam logic [3:0]   INIT_LEN  = 4'd2;
  localparam logic [127:0] INIT_LOCS = {INIT_HEAD, INIT_SEG1, 112'd0};

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; the all-zero state is unreachable from a nonzero seed
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic dir_e dir_reverse(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

  // Flag order {init, play, collect, win, lose}
  function automatic logic [4:0] state_flags(input state_e s);
    logic [4:0] f;
    case (s)
      ST_INIT:             f = 5'b10000;
      ST_PLAY:             f = 5'b01000;
      ST_SEARCH, ST_PLACE: f = 5'b00100;
      ST_WIN:              f = 5'b00010;
      ST_LOSE:             f = 5'b00001;
      default:             f = 5'b10000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/snake_occupancy.sv
// Combinational occupancy test: does cell_i match any of the first count_i segments?
module snake_occupancy
  import snake_pkg::*;
(
  input  logic [7:0]   cell_i,
  input  logic [127:0] segs_i,
  input  logic [4:0]   count_i,
  output logic         hit_o
);

  // OR-reduce the per-segment matches inside the active window
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NUM_SEGS; i++) begin
      hit_o = hit_o | ((5'(i) < count_i) && (segs_i[127-8*i -: 8] == cell_i));
    end
  end

endmodule

// File: rtl/snake_game_engine.sv
// Snake game-state sequencer: body, food, length and state flags, one grid step per Tick.
// Define SNAKE_WRAP_EN to make the walls wrap around instead of ending the game.
module snake_game_engine
  import snake_pkg::*;
#(
  parameter int WIN_LEN = 15
)(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Tick,
  input  logic         Start,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnL,
  input  logic         BtnR,
  output logic         Qi,
  output logic         Qp,
  output logic         Qc,
  output logic         Qw,
  output logic         Ql,
  output logic [3:0]   Length,
  output logic [7:0]   Food,
  output logic [127:0] Locations_Flat
);

`ifdef SNAKE_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  state_e       state_q, state_d;
  dir_e         dir_q, dir_d, dir_req, dir_eff;
  logic [127:0] locs_q, locs_d;
  logic [3:0]   len_q, len_d;
  logic [7:0]   food_q, food_d;
  logic [7:0]   lfsr_q, lfsr_d;
  logic [4:0]   flags_q;

  logic [3:0] hx, hy, nx, ny;
  logic [7:0] next_head;
  logic       at_edge, wall_hit, eat, self_hit, search_hit;
  logic [4:0] self_cnt;

  assign hx        = locs_q[123:120];
  assign hy        = locs_q[127:124];
  assign next_head = {ny, nx};
  assign wall_hit  = at_edge & ~WRAP_EN;
  assign eat       = (next_head == food_q);
  // When not eating the tail moves away this step, so its cell is not an obstacle
  assign self_cnt  = eat ? {1'b0, len_q} : ({1'b0, len_q} - 5'd1);

  // Button priority U > D > L > R; a reversal request keeps the current heading
  always_comb begin
    if (BtnU) begin
      dir_req = DIR_UP;
    end else if (BtnD) begin
      dir_req = DIR_DOWN;
    end else if (BtnL) begin
      dir_req = DIR_LEFT;
    end else if (BtnR) begin
      dir_req = DIR_RIGHT;
    end else begin
      dir_req = dir_q;
    end
    if (dir_req == dir_reverse(dir_q)) begin
      dir_eff = dir_q;
    end else begin
      dir_eff = dir_req;
    end
  end

  // Next head position on 4-bit nibbles, flagging steps off the grid
  always_comb begin
    nx      = hx;
    ny      = hy;
    at_edge = 1'b0;
    case (dir_eff)
      DIR_UP:    begin ny = hy - 4'd1; at_edge = (hy == 4'd0);             end
      DIR_DOWN:  begin ny = hy + 4'd1; at_edge = (hy == 4'(GRID_H - 1));   end
      DIR_LEFT:  begin nx = hx - 4'd1; at_edge = (hx == 4'd0);             end
      DIR_RIGHT: begin nx = hx + 4'd1; at_edge = (hx == 4'(GRID_W - 1));   end
      default:   begin nx = hx; ny = hy; at_edge = 1'b0;                  end
    endcase
  end

  snake_occupancy u_self_occ (
    .cell_i  (next_head),
    .segs_i  (locs_q),
    .count_i (self_cnt),
    .hit_o   (self_hit)
  );

  snake_occupancy u_search_occ (
    .cell_i  (lfsr_q),
    .segs_i  (locs_q),
    .count_i ({1'b0, len_q}),
    .hit_o   (search_hit)
  );

  // Game sequencing: next-state for the FSM and everything it owns
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    locs_d  = locs_q;
    len_d   = len_q;
    food_d  = food_q;
    lfsr_d  = lfsr_step(lfsr_q);
    case (state_q)
      ST_INIT: begin
        if (Start) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_PLAY: begin
        dir_d = dir_eff;
        if (Tick && (wall_hit || self_hit)) begin
          state_d = ST_LOSE;
        end else if (Tick) begin
          locs_d = {next_head, locs_q[127:8]};
          if (!eat) begin
            state_d = ST_PLAY;
          end else if (({1'b0, len_q} + 5'd1) == 5'(WIN_LEN)) begin
            len_d   = len_q + 4'd1;
            state_d = ST_WIN;
          end else begin
            len_d   = len_q + 4'd1;
            state_d = ST_SEARCH;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_SEARCH: begin
        if (!search_hit) begin
          food_d  = lfsr_q;
          state_d = ST_PLACE;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_PLACE: state_d = ST_PLAY;
      ST_WIN, ST_LOSE: begin
        if (Start) begin
          state_d = ST_INIT;
          dir_d   = DIR_RIGHT;
          locs_d  = INIT_LOCS;
          len_d   = INIT_LEN;
          food_d  = INIT_FOOD;
          lfsr_d  = LFSR_SEED;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_INIT;
      dir_q   <= DIR_RIGHT;
      locs_q  <= INIT_LOCS;
      len_q   <= INIT_LEN;
      food_q  <= INIT_FOOD;
      lfsr_q  <= LFSR_SEED;
      flags_q <= 5'b10000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      locs_q  <= locs_d;
      len_q   <= len_d;
      food_q  <= food_d;
      lfsr_q  <= lfsr_d;
      flags_q <= state_flags(state_d);
    end
  end

  assign {Qi, Qp, Qc, Qw, Ql} = flags_q;
  assign Length               = len_q;
  assign Food                 = food_q;
  assign Locations_Flat       = locs_q;

endmodule
